// File: rtl/bus_pkg.sv
// Shared IDs, header layout and FSM encoding for the bus arbiter.
package bus_pkg;

   localparam int         N_REQ        = 3;
   localparam logic [1:0] CTRL_ID      = 2'b11;
   localparam int         HDR_PORT_LSB = 0;
   localparam int         HDR_SRC_LSB  = 2;
   localparam int         HDR_DEST_LSB = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_XFER    = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   function automatic logic [7:0] make_hdr(input logic [1:0] dest, input logic [1:0] src);
      logic [7:0] h;
      h = '0;
      h[HDR_DEST_LSB +: 2] = dest;
      h[HDR_SRC_LSB  +: 2] = src;
      h[HDR_PORT_LSB +: 2] = CTRL_ID;
      return h;
   endfunction

   function automatic logic [1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
      logic [1:0] id;
      case (oh)
         3'b010:  id = 2'd1;
         3'b100:  id = 2'd2;
         default: id = 2'd0;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Three-way round-robin picker: searches last_grant+1, +2, +3 (mod 3).
module rr_picker
   import bus_pkg::*;
(
   input  logic [N_REQ-1:0] eligible,
   input  logic [1:0]       last_grant,
   output logic [N_REQ-1:0] winner
);

   logic [1:0] w_idx;
   logic       w_found;

   always_comb begin
      winner  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = 2'((int'(last_grant) + k) % N_REQ);
         if (!w_found && eligible[w_idx]) begin
            winner[w_idx] = 1'b1;
            w_found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: header out through the control port, settle, grant, release.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [5:0]       req_dest,
   output logic             hdr_valid,
   output logic [7:0]       hdr_data,
   input  logic             hdr_ready,
   input  logic             bus_valid,
   input  logic             ack_in,
   output logic [N_REQ-1:0] grant,
   output logic             ack_out,
   output logic             busy,
   output logic             err_timeout,
   output logic             err_dest
);

   localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [N_REQ-1:0] r_win;
   logic [1:0]       r_win_id;
   logic [1:0]       r_last_grant;
   logic             r_hdr_valid;
   logic [7:0]       r_hdr_data;
   logic [N_REQ-1:0] r_grant;
   logic             r_ack_out;
   logic             r_busy;
   logic             r_err_timeout;
   logic             r_err_dest;

   logic [N_REQ-1:0] w_eligible;
   logic [N_REQ-1:0] w_illegal;
   logic [N_REQ-1:0] w_winner;
   logic [1:0]       w_win_id;
   logic [1:0]       w_win_dest;

   // A requester may not target the control port or itself.
   always_comb begin
      w_eligible = '0;
      w_illegal  = '0;
      for (int n = 0; n < N_REQ; n++) begin
         if (req_dest[2*n +: 2] != CTRL_ID && req_dest[2*n +: 2] != 2'(n))
            w_eligible[n] = req[n];
         else
            w_illegal[n]  = req[n];
      end
   end

   rr_picker u_picker (
      .eligible   (w_eligible),
      .last_grant (r_last_grant),
      .winner     (w_winner)
   );

   assign w_win_id   = onehot_to_id(w_winner);
   assign w_win_dest = req_dest[2*int'(w_win_id) +: 2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_win         <= '0;
         r_win_id      <= '0;
         r_last_grant  <= 2'd2;
         r_hdr_valid   <= 1'b0;
         r_hdr_data    <= '0;
         r_grant       <= '0;
         r_ack_out     <= 1'b0;
         r_busy        <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_dest    <= 1'b0;
      end else begin
         r_err_dest    <= |w_illegal;
         r_ack_out     <= 1'b0;
         r_err_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|w_eligible) begin
                  r_state     <= ST_HEADER;
                  r_win       <= w_winner;
                  r_win_id    <= w_win_id;
                  r_hdr_data  <= make_hdr(w_win_dest, w_win_id);
                  r_hdr_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_HEADER: begin
               if (r_hdr_valid && hdr_ready) begin
                  r_hdr_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_cnt   <= '0;
                  r_grant <= r_win;
                  r_state <= ST_XFER;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_XFER: begin
               // ack_in is checked first so a coincident timeout is not flagged.
               if (ack_in) begin
                  r_grant   <= '0;
                  r_ack_out <= 1'b1;
                  r_state   <= ST_RELEASE;
               end else if (bus_valid) begin
                  r_cnt <= '0;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_grant       <= '0;
                  r_ack_out     <= 1'b1;
                  r_err_timeout <= 1'b1;
                  r_state       <= ST_RELEASE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               r_last_grant <= r_win_id;
               r_cnt        <= '0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_grant     <= '0;
               r_hdr_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign hdr_valid   = r_hdr_valid;
   assign hdr_data    = r_hdr_data;
   assign grant       = r_grant;
   assign ack_out     = r_ack_out;
   assign busy        = r_busy;
   assign err_timeout = r_err_timeout;
   assign err_dest    = r_err_dest;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed transfers, a queue-based scoreboard checks
// headers, grant order and release flags as the DUT presents them.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] req = '0;
   logic [5:0] req_dest = '0;
   logic       hdr_ready = 1'b1;
   logic       bus_valid = 1'b0;
   logic       ack_in = 1'b0;
   logic       hdr_valid;
   logic [7:0] hdr_data;
   logic [2:0] grant;
   logic       ack_out;
   logic       busy;
   logic       err_timeout;
   logic       err_dest;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_hdr[$];
   logic [2:0] exp_grant[$];
   logic       exp_err[$];
   logic [2:0] prev_grant = '0;

   bus_arbiter #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(255)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_dest    (req_dest),
      .hdr_valid   (hdr_valid),
      .hdr_data    (hdr_data),
      .hdr_ready   (hdr_ready),
      .bus_valid   (bus_valid),
      .ack_in      (ack_in),
      .grant       (grant),
      .ack_out     (ack_out),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_dest    (err_dest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int max);
      int c;
      c = 0;
      while (grant == 3'b000 && c < max) begin
         tick(1);
         c++;
      end
      if (grant == 3'b000) begin
         checks++;
         errors++;
         $display("FAIL wait_grant no grant within %0d cycles", max);
      end
   endtask

   task automatic do_ack();
      ack_in = 1'b1;
      tick(1);
      ack_in = 1'b0;
      chk("ack_out_release", {29'd0, ack_out, grant}, {29'd0, 1'b1, 3'b000});
      tick(1);
      chk("busy_back_idle", busy, 0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_grant = '0;
         end else begin
            if (hdr_valid && hdr_ready) begin
               if (exp_hdr.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL hdr_unexpected actual=%0h expected=none", hdr_data);
               end else chk("hdr_data", hdr_data, exp_hdr.pop_front());
            end
            if (grant != 3'b000 && prev_grant == 3'b000) begin
               if (exp_grant.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL grant_unexpected actual=%0b expected=none", grant);
               end else chk("grant_order", grant, exp_grant.pop_front());
            end
            if (ack_out) begin
               if (exp_err.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL ack_unexpected actual=1 expected=none");
               end else chk("err_timeout_at_ack", err_timeout, exp_err.pop_front());
            end else if (err_timeout) begin
               chk("err_without_ack", err_timeout, ack_out);
            end
            prev_grant = grant;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      tick(2);
      chk("reset_grant", grant, 0);
      chk("reset_hdr", {23'd0, hdr_valid, hdr_data}, 0);
      chk("reset_flags", {28'd0, ack_out, busy, err_timeout, err_dest}, 0);
      rst_n = 1'b1;
      tick(1);

      // single requester 1 -> dest 0, minimum latency, req dropped mid-transfer
      req_dest = 6'b00_00_01;
      exp_hdr.push_back(8'h07); exp_grant.push_back(3'b010); exp_err.push_back(1'b0);
      req = 3'b010;
      tick(4);
      chk("latency_not_yet", grant, 0);
      chk("busy_in_settle", busy, 1);
      req = 3'b000;
      tick(1);
      chk("latency_five", grant, 3'b010);
      bus_valid = 1'b1;
      tick(3);
      chk("grant_held_no_req", grant, 3'b010);
      bus_valid = 1'b0;
      do_ack();

      // round robin from reset with all three requesting
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
      req_dest = 6'b00_10_01;
      exp_hdr.push_back(8'h13); exp_hdr.push_back(8'h27);
      exp_hdr.push_back(8'h0B); exp_hdr.push_back(8'h13);
      exp_grant.push_back(3'b001); exp_grant.push_back(3'b010);
      exp_grant.push_back(3'b100); exp_grant.push_back(3'b001);
      for (int i = 0; i < 4; i++) exp_err.push_back(1'b0);
      req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         wait_grant(20);
         if (i == 3) req = 3'b000;
         do_ack();
      end
      chk("err_dest_legal", err_dest, 0);

      // header backpressure, then timeout on an idle bus
      hdr_ready = 1'b0;
      req_dest = 6'b00_00_10;
      exp_hdr.push_back(8'h23); exp_grant.push_back(3'b001); exp_err.push_back(1'b1);
      req = 3'b001;
      tick(3);
      chk("stall_hdr_valid", hdr_valid, 1);
      chk("stall_hdr_data", hdr_data, 8'h23);
      tick(2);
      chk("stall_hdr_data_stable", {23'd0, hdr_valid, hdr_data}, {23'd0, 1'b1, 8'h23});
      hdr_ready = 1'b1;
      req = 3'b000;
      wait_grant(20);
      begin
         int n;
         n = 0;
         while (!ack_out && n < 300) begin
            tick(1);
            n++;
         end
         chk("timeout_cycles", n, 255);
      end
      chk("timeout_err", err_timeout, 1);
      chk("timeout_grant_off", grant, 0);
      tick(1);
      chk("timeout_pulse_one", {30'd0, err_timeout, ack_out}, 0);
      tick(1);

      // bus activity restarts the idle count; ack on the final count wins
      req_dest = 6'b00_00_00;
      exp_hdr.push_back(8'h07); exp_grant.push_back(3'b010); exp_err.push_back(1'b0);
      req = 3'b010;
      wait_grant(20);
      req = 3'b000;
      tick(99);
      bus_valid = 1'b1;
      tick(1);
      bus_valid = 1'b0;
      tick(254);
      chk("no_early_timeout", grant, 3'b010);
      ack_in = 1'b1;
      tick(1);
      ack_in = 1'b0;
      chk("ackwin_ack", ack_out, 1);
      chk("ackwin_err", err_timeout, 0);
      tick(1);

      // illegal destinations
      req_dest = 6'b00_00_00;
      req = 3'b001;
      tick(2);
      chk("err_dest_self", err_dest, 1);
      chk("busy_self_dest", busy, 0);
      tick(5);
      chk("busy_stays_low", busy, 0);
      req_dest = 6'b11_00_00;
      req = 3'b100;
      tick(2);
      chk("err_dest_ctrl", {30'd0, err_dest, busy}, {30'd0, 1'b1, 1'b0});
      req = 3'b000;
      tick(2);
      chk("err_dest_clear", err_dest, 0);
      req_dest = 6'b00_00_00;
      exp_hdr.push_back(8'h07); exp_grant.push_back(3'b010); exp_err.push_back(1'b0);
      req = 3'b011;
      tick(2);
      chk("err_dest_mixed", err_dest, 1);
      wait_grant(20);
      req = 3'b000;
      do_ack();

      // reset during XFER, then ack_in outside XFER is ignored
      req_dest = 6'b00_00_01;
      exp_hdr.push_back(8'h13); exp_grant.push_back(3'b001);
      req = 3'b001;
      wait_grant(20);
      req = 3'b000;
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grant_async", grant, 0);
      chk("rst_no_ack", {30'd0, ack_out, busy}, 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      ack_in = 1'b1;
      req_dest = 6'b00_00_00;
      exp_hdr.push_back(8'h0B); exp_grant.push_back(3'b100); exp_err.push_back(1'b0);
      req = 3'b100;
      wait_grant(20);
      ack_in = 1'b0;
      req = 3'b000;
      tick(1);
      chk("ack_ignored_outside", grant, 3'b100);
      do_ack();

      tick(2);
      chk("exp_hdr_left", exp_hdr.size(), 0);
      chk("exp_grant_left", exp_grant.size(), 0);
      chk("exp_err_left", exp_err.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3: cycles from header acceptance to grant.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: idle-bus cycles in XFER before forced release.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  3  per-module bus request; bit n = module ID n.
REQ-006 SHALL have port req_dest  input  6  destination ID per requester; bits [2n+1:2n] belong to requester n.
REQ-007 SHALL have port hdr_valid  output  1  header packet valid, sent through the control (ID 2'b11) data_bus port.
REQ-008 SHALL have port hdr_data  output  8  header: [7:6]=2'b00, [5:4]=dest, [3:2]=src, [1:0]=2'b11.
REQ-009 SHALL have port hdr_ready  input  1  control port send_ready.
REQ-010 SHALL have port bus_valid  input  1  monitored shared-bus valid.
REQ-011 SHALL have port ack_in  input  1  last-packet indication from the granted module.
REQ-012 SHALL have port grant  output  3  one-hot grant; zero when no transfer is in XFER.
REQ-013 SHALL have port ack_out  output  1  one-cycle end-of-transfer broadcast to all data_bus ack inputs.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port err_timeout  output  1  one-cycle pulse on forced release.
REQ-016 SHALL have port err_dest  output  1  high while any active requester has an illegal destination.

Function
REQ-017 SHALL use states IDLE, HEADER, SETTLE, XFER, RELEASE; all outputs registered.
REQ-018 Requester n SHALL be eligible when req[n]=1, req_dest[n] != 2'b11 and req_dest[n] != n; ineligible active requesters SHALL be skipped and raise err_dest.
REQ-019 IDLE: one or more eligible requesters -> HEADER next cycle; winner = first eligible in order last_grant+1, +2, +3 (mod 3).
REQ-020 Winner ID and its destination SHALL be latched on leaving IDLE; later req/req_dest changes SHALL NOT affect the transfer in progress.
REQ-021 HEADER: hdr_valid=1 with hdr_data stable until the cycle hdr_valid and hdr_ready are both 1; next cycle -> SETTLE, hdr_valid=0.
REQ-022 SETTLE: count SETTLE_CYCLES cycles, then -> XFER; grant[winner]=1 from the first XFER cycle.
REQ-023 XFER: idle counter clears on every bus_valid=1 cycle and increments otherwise; reaching TIMEOUT_CYCLES -> RELEASE with err_timeout=1 for one cycle.
REQ-024 XFER: ack_in=1 -> RELEASE; ack_in and timeout in the same cycle: ack wins, no err_timeout.
REQ-025 RELEASE: lasts exactly one cycle; ack_out=1, grant=0; last_grant <= winner; -> IDLE.
REQ-026 Dropping req during HEADER/SETTLE/XFER SHALL NOT abort; the transfer ends only via ack_in or timeout.
REQ-027 ack_in outside XFER SHALL be ignored.
REQ-028 Minimum request-to-grant latency SHALL be 2+SETTLE_CYCLES cycles with hdr_ready tied high.
REQ-029 A requester with req still high after RELEASE SHALL compete again from IDLE under round-robin rules.

Reset
REQ-030 On rst_n=0: state IDLE, grant=0, hdr_valid=0, hdr_data=0, ack_out=0, busy=0, err_timeout=0, err_dest=0, counters=0, last_grant=2 (so ID 0 wins first).
REQ-031 Reset asserted mid-transfer SHALL release grant immediately, with no ack_out pulse.

Structure
REQ-032 Shared package bus_pkg SHALL hold ID constants (CTRL_ID=2'b11), header field positions, and the state encoding.
REQ-033 The 3-way round-robin picker SHALL be the sub-module rr_picker (inputs eligible[2:0], last_grant; output one-hot winner).

Verification
REQ-034 req=3'b010, req_dest[3:2]=2'b00, hdr_ready=1 -> hdr_data=8'h07 and grant=3'b010 five cycles after req.
REQ-035 req=3'b111 held, ack_in after each grant -> grant order 001, 010, 100, 001.
REQ-036 Granted, bus_valid=0 for 255 cycles -> err_timeout and ack_out pulse in the same cycle, grant=0.
REQ-037 ack_in on the same cycle the timeout count completes -> ack_out=1, err_timeout=0.
REQ-038 req=3'b001 with req_dest[1:0]=2'b00 -> err_dest=1, busy stays 0.
REQ-039 rst_n pulled low during XFER -> grant=0 asynchronously, ack_out=0; next req=3'b100 wins with hdr_data=8'h0B for dest 0.
